dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: a word-addressed store that answers one load or
// store per transfer after a fixed number of wait states. It also sets a
// sticky Pass flag once the word 7 has been stored to byte address 0x64.
module dmem_responder #(
  parameter int WORDS   = 64,
  parameter int WAITCYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AdrErr,
  output logic        Pass
);

  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        pass_q;
  logic [31:0] mem_q [WORDS];

  logic [IW-1:0] idx;
  logic          adr_bad;
  logic          commit;

  // All decoding works on the captured address. Inputs are not used again
  // once a transfer is in flight.
  assign idx     = adr_q[IW+1:2];
  assign adr_bad = (adr_q[1:0] != 2'b00) || (adr_q >= 32'(4 * WORDS));
  assign commit  = (state_q == S_RESP) && we_q && !adr_bad;

  assign Ready    = (state_q == S_RESP);
  assign AdrErr   = Ready && adr_bad;
  // A store shows the old word here, because the write only lands at the end of RESP.
  assign ReadData = (Ready && !adr_bad) ? mem_q[idx] : 32'd0;
  assign Pass     = pass_q;

  // Next-state logic: capture the request in IDLE, count wait states, then respond for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          adr_d   = Adr;
          wdata_d = WriteData;
          we_d    = MemWrite;
          if (WAITCYC == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAITCYC);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and capture registers. Reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // Word array. Reset clears every word, so this maps to registers rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (commit) begin
      mem_q[idx] <= wdata_q;
    end
  end

  // Sticky pass flag. Only a committed store of 7 to byte 0x64 sets it.
  // The legality check already rules out 0x64 when the array is too small.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q <= 1'b0;
    end else if (commit && (adr_q == 32'h64) && (wdata_q == 32'd7)) begin
      pass_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder. A word-array model
// predicts load data, address errors, the Pass flag and response latency.
module tb_dmem_responder;

  localparam int W  = 64;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req, MemWrite;
  logic [31:0] Adr, WriteData, ReadData;
  logic        Ready, AdrErr, Pass;

  logic        Req0, MemWrite0;
  logic [31:0] Adr0, WriteData0, ReadData0;
  logic        Ready0, AdrErr0, Pass0;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [W];
  bit          pass_m;

  dmem_responder #(.WORDS(W), .WAITCYC(WC)) dut (
    .clk(clk), .reset(reset), .Req(Req), .MemWrite(MemWrite), .Adr(Adr),
    .WriteData(WriteData), .ReadData(ReadData), .Ready(Ready),
    .AdrErr(AdrErr), .Pass(Pass)
  );

  dmem_responder #(.WORDS(W), .WAITCYC(0)) dut_nw (
    .clk(clk), .reset(reset), .Req(Req0), .MemWrite(MemWrite0), .Adr(Adr0),
    .WriteData(WriteData0), .ReadData(ReadData0), .Ready(Ready0),
    .AdrErr(AdrErr0), .Pass(Pass0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < W; i++) model[i] = 32'd0;
    pass_m = 1'b0;
  endtask

  // One transfer. The caller is at a falling edge with the DUT idle.
  // The bench drives the request, scrambles the inputs during the wait, then checks the response.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bit          legal;
    bit          got;
    int          idx;
    logic [31:0] exp_rd;
    legal  = (adr[1:0] == 2'b00) && (adr < 32'(4 * W));
    idx    = legal ? int'(adr >> 2) : 0;
    exp_rd = legal ? model[idx] : 32'd0;
    Req = 1'b1; MemWrite = we; Adr = adr; WriteData = wd;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        Req = 1'b0;
        MemWrite = 1'($urandom_range(0, 1));
        Adr = $urandom;
        WriteData = $urandom;
      end
      if (Ready) begin
        got = 1'b1;
        chk("latency", 32'(k), 32'(1 + WC));
        chk("adrerr", {31'd0, AdrErr}, {31'd0, !legal});
        chk("rdata", ReadData, exp_rd);
      end else begin
        chk("idle_err", {31'd0, AdrErr}, 32'd0);
        chk("idle_rdata", ReadData, 32'd0);
      end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    if (legal && we) begin
      model[idx] = wd;
      if (adr == 32'h64 && wd == 32'd7) pass_m = 1'b1;
    end
    $display("xfer we=%0d adr=%h wd=%h legal=%0d exp_rd=%h", we, adr, wd, legal, exp_rd);
    @(negedge clk);
    chk("ready_pulse", {31'd0, Ready}, 32'd0);
    chk("pass", {31'd0, Pass}, {31'd0, pass_m});
  endtask

  // Req is held high while four loads are queued. The requested address is
  // only presented in the cycles where an acceptance is due; other cycles
  // carry decoy addresses that must be ignored.
  task automatic b2b();
    logic [31:0] alist [4];
    int          slot;
    for (int i = 0; i < 4; i++) alist[i] = 32'($urandom_range(0, W - 1)) << 2;
    for (int c = 0; c < 16; c++) begin
      Req = 1'b1;
      MemWrite = 1'b0;
      WriteData = $urandom;
      if (c % 4 == 0) Adr = alist[c / 4];
      else            Adr = 32'($urandom_range(0, W - 1)) << 2;
      @(negedge clk);
      if ((c + 1) % 4 == 3) begin
        slot = (c + 1) / 4;
        chk("b2b_ready", {31'd0, Ready}, 32'd1);
        chk("b2b_rdata", ReadData, model[int'(alist[slot] >> 2)]);
        $display("b2b load adr=%h exp=%h got=%h", alist[slot], model[int'(alist[slot] >> 2)], ReadData);
      end else begin
        chk("b2b_ready", {31'd0, Ready}, 32'd0);
      end
    end
    Req = 1'b0;
  endtask

  // Start a store, then pulse reset during its first wait cycle.
  task automatic mid_reset(input logic [31:0] adr, input logic [31:0] wd);
    Req = 1'b1; MemWrite = 1'b1; Adr = adr; WriteData = wd;
    @(negedge clk);
    Req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      chk("rst_no_ready", {31'd0, Ready}, 32'd0);
      @(negedge clk);
    end
    chk("rst_pass", {31'd0, Pass}, 32'd0);
    $display("mid-transfer reset on store adr=%h wd=%h", adr, wd);
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1:    a = 32'($urandom_range(0, W - 1)) << 2;
      2:       a = 32'h64;
      3:       a = (32'($urandom_range(0, W - 1)) << 2) | 32'($urandom_range(1, 3));
      default: a = 32'(4 * W) + ($urandom % 32'h1000);
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] a, d;
    Req = 1'b0; MemWrite = 1'b0; Adr = 32'd0; WriteData = 32'd0;
    Req0 = 1'b0; MemWrite0 = 1'b0; Adr0 = 32'd0; WriteData0 = 32'd0;
    reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, Ready}, 32'd0);
    chk("rst_adrerr", {31'd0, AdrErr}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_pass", {31'd0, Pass}, 32'd0);
    chk("rst_pass_nw", {31'd0, Pass0}, 32'd0);

    // Store then load back.
    xfer(1'b1, 32'h10, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 32'd0);
    // The Pass flag sets on the store of 7 and stays set when another value is stored there.
    xfer(1'b1, 32'h64, 32'd7);
    xfer(1'b1, 32'h64, 32'd5);
    xfer(1'b0, 32'h64, 32'd0);
    // Illegal addresses, followed by proof that nothing was written.
    xfer(1'b0, 32'h12, 32'd0);
    xfer(1'b1, 32'h100, 32'hCAFEF00D);
    xfer(1'b0, 32'h00, 32'd0);
    // A reset in the middle of a transfer abandons it.
    mid_reset(32'h20, 32'h1234);
    xfer(1'b0, 32'h20, 32'd0);

    // Random traffic.
    for (int n = 0; n < 90; n++) begin
      a = rand_adr();
      d = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
      xfer(1'($urandom_range(0, 1)), a, d);
    end
    b2b();
    b2b();
    xfer(1'b0, 32'h64, 32'd0);

    // Build with no wait states: the response comes one cycle after the request.
    Req0 = 1'b1; MemWrite0 = 1'b1; Adr0 = 32'h64; WriteData0 = 32'd7;
    @(negedge clk);
    Req0 = 1'b0;
    chk("nw_ready", {31'd0, Ready0}, 32'd1);
    chk("nw_adrerr", {31'd0, AdrErr0}, 32'd0);
    chk("nw_pass_pre", {31'd0, Pass0}, 32'd0);
    @(negedge clk);
    chk("nw_ready_pulse", {31'd0, Ready0}, 32'd0);
    chk("nw_pass", {31'd0, Pass0}, 32'd1);
    $display("nowait store adr=64 wd=7 pass=%0d", Pass0);
    Req0 = 1'b1; MemWrite0 = 1'b0; Adr0 = 32'h64;
    @(negedge clk);
    Req0 = 1'b0;
    chk("nw_load_ready", {31'd0, Ready0}, 32'd1);
    chk("nw_load_rdata", ReadData0, 32'd7);
    $display("nowait load adr=64 got=%h", ReadData0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
